key_pulse_conditioner: RTL and testbench
========================================

# key_pulse_conditioner

Upstream conditioning stage for the 4-bit T-flip-flop counter with hex display. It takes a raw, active-low, bouncing pushbutton, synchronises it to the system clock, and debounces it. It then emits a single-cycle `pulse` that the counter consumes as its count enable, replacing the direct use of the key as a clock. A level output and a release pulse are also provided for other consumers.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required to accept a press or a release (5 ms at 50 MHz); legal range ≥ 2.
- `REPEAT_DELAY`, 25000000: cycles held before the first auto-repeat pulse; used only with `KEY_AUTOREPEAT_EN`.
- `REPEAT_RATE`, 5000000: cycles between subsequent auto-repeat pulses; used only with `KEY_AUTOREPEAT_EN`.

Ports:
- `clk` input, 1: system clock; all state updates on its rising edge.
- `areset` input, 1: one clock; reset is asynchronous and active-high.
- `key_n` input, 1: raw pushbutton, 0 = pressed; asynchronous to `clk`.
- `pulse` output, 1: one-cycle strobe per accepted press (and per repeat).
- `pressed` output, 1: debounced level, 1 while the key is accepted as held.
- `released` output, 1: one-cycle strobe per accepted release.

## Operation
- Synchroniser: two flops on `key_n`, both reset to 1. Internal `k = ~sync2`.
- One counter is sized `$clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)+1)` bits. It is cleared on every state change. It never wraps; it saturates at its terminal value.
- FSM states:
  - IDLE: if `k`=1, go to DEB_PRESS with counter = 1.
  - DEB_PRESS: if `k`=0, return to IDLE. Else increment. When the counter equals `DEBOUNCE_CYCLES` with `k`=1, go to HELD and assert `pulse`.
  - HELD: if `k`=0, go to DEB_REL with counter = 1. Auto-repeat logic runs here only (see Configuration).
  - DEB_REL: if `k`=1, return to HELD. This bounce does not re-pulse and restarts the repeat timing from zero. Else increment. At `DEBOUNCE_CYCLES` with `k`=0, go to IDLE and assert `released`.
- `pressed` = 1 in HELD and DEB_REL, 0 otherwise.
- All outputs are registered; no combinational path from `key_n` to any output.
- `pulse` and `released` are never high in the same cycle. Neither is ever high for two consecutive cycles.

## Timing
- Reset values: `pulse`=0, `pressed`=0, `released`=0, state IDLE, counter 0, synchroniser flops = 1.
- Press latency: let `key_n`=0 first be captured at edge N, held steady.
  - `k`=1 is visible from edge N+1.
  - DEB_PRESS is entered at edge N+2.
  - `pulse` and `pressed` rise at edge N+1+`DEBOUNCE_CYCLES`. `pulse` falls one edge later.
- Release latency: symmetric. `released` rises at edge M+1+`DEBOUNCE_CYCLES` and `pressed` falls at the same edge.
- Bounce: any opposite sample inside a debounce window restarts that window from zero. A glitch of 1 to `DEBOUNCE_CYCLES`−1 cycles produces no output.
- Reset mid-operation: all state is cleared immediately, including a pending pulse. A key still held when `areset` deasserts is debounced from IDLE again and yields exactly one `pulse`.
- Key held at power-up: treated as a new press after debounce.

## Configuration
- `KEY_AUTOREPEAT_EN` defined:
  - In HELD, a repeat timer counts from entry.
  - At `REPEAT_DELAY` cycles, `pulse` fires and the timer reloads.
  - Thereafter `pulse` fires every `REPEAT_RATE` cycles while in HELD.
  - DEB_REL freezes the timer. A return to HELD restarts it at zero, with the next pulse due `REPEAT_DELAY` later.
- `KEY_AUTOREPEAT_EN` undefined: exactly one `pulse` per press regardless of hold time; the repeat timer and its compare logic are not synthesised.

## Test plan
Use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_RATE`=3.
- Clean press: `key_n` 1→0 captured at edge 10 and held → `pulse`=1 only at edge 15, `pressed`=1 from edge 15; `key_n`→1 at edge 30 → `released`=1 only at edge 35, `pressed`=0 at edge 35.
- Bounce: `key_n` low 3 cycles, high 1, low 2, high → no `pulse`, `pressed` stays 0. Then held low → exactly one `pulse` 5 edges after the last low capture.
- Release bounce: while HELD, `key_n` high 2 cycles then low → `pressed` stays 1, no `released`, no extra `pulse`.
- Reset mid-debounce: `areset` pulse at DEB_PRESS counter=3 → all outputs 0 at once. Key still held → `pulse` at edge deassert+6.
- Auto-repeat (macro on): hold key 30 cycles after first `pulse` → further pulses 10, 13, 16, 19, … cycles after the first. Macro off → no pulses after the first.
- Counter integration: drive `pulse` into the 4-bit counter enable; 17 clean presses → display wraps 0→F→0→1.

Source files
------------

// File: rtl/key_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// key_pulse_conditioner
//
// Turns a raw, bouncing, active-low pushbutton into clean single-clock events
// for the 4-bit counter. The button is brought into the clk domain, debounced,
// and presented to the counter as a one-cycle count enable, so the key is
// never used as a clock.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable samples needed to accept a press or
//                     a release (>= 2)
//   REPEAT_DELAY    : cycles held in HELD before the first auto-repeat pulse
//   REPEAT_RATE     : cycles between later auto-repeat pulses
//
// Ports:
//   clk      in  : system clock, rising edge
//   areset   in  : asynchronous, active-high reset
//   key_n    in  : raw pushbutton, 0 = pressed, asynchronous to clk
//   pulse    out : one-cycle strobe per accepted press (and per repeat)
//   pressed  out : debounced level, 1 while the key is accepted as held
//   released out : one-cycle strobe per accepted release
//
// Build option:
//   KEY_AUTOREPEAT_EN : when defined, holding the key produces repeat pulses
//                       after REPEAT_DELAY and then every REPEAT_RATE cycles.
//                       When undefined, exactly one pulse per press and the
//                       repeat timing logic is not built at all.
// -----------------------------------------------------------------------------
module key_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic areset,
  input  logic key_n,
  output logic pulse,
  output logic pressed,
  output logic released
);

  // ---------------------------------------------------------------------------
  // Counter sizing: one counter serves both debounce windows and the repeat
  // timer, so it must hold the largest terminal value of the three.
  // ---------------------------------------------------------------------------
  localparam int MAX_DEB_DLY = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES
                                                               : REPEAT_DELAY;
  localparam int MAX_ALL     = (MAX_DEB_DLY > REPEAT_RATE) ? MAX_DEB_DLY
                                                           : REPEAT_RATE;
  localparam int CNT_W       = $clog2(MAX_ALL + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_ZERO = '0;
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_MAX  = '1;
  localparam cnt_t DEB_TERM = cnt_t'(DEBOUNCE_CYCLES);

`ifdef KEY_AUTOREPEAT_EN
  localparam cnt_t DELAY_TERM = cnt_t'(REPEAT_DELAY);
  localparam cnt_t RATE_TERM  = cnt_t'(REPEAT_RATE);
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. Both flops reset to 1 (key released) so a reset
  // never looks like a press; a key held through reset is seen as a fresh
  // falling edge once reset lifts.
  // ---------------------------------------------------------------------------
  logic sync1;
  logic sync2;
  logic k;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Active-high, synchronised key level.
  assign k = ~sync2;

  // ---------------------------------------------------------------------------
  // State, counter and registered outputs.
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_d;
  cnt_t   cnt;
  cnt_t   cnt_d;
  cnt_t   cnt_inc;
  logic   pulse_d;
  logic   released_d;
  logic   pressed_d;

`ifdef KEY_AUTOREPEAT_EN
  // Set once the first repeat has fired, so the timer then compares against
  // REPEAT_RATE instead of REPEAT_DELAY.
  logic repeating;
  logic repeating_d;
`endif

  // Saturating increment: the counter parks at its maximum rather than
  // wrapping back to a value that could match a terminal count again.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

  // cnt holds the number of consecutive qualifying samples taken so far in the
  // current window. The window completes on the edge whose sample brings the
  // count to its terminal value, which is why compares use cnt_inc: the
  // outputs are registered and must rise on that same edge.
  //
  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    pulse_d     = 1'b0;
    released_d  = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    repeating_d = repeating;
`endif

    unique case (state)
      IDLE: begin
        cnt_d = CNT_ZERO;
        if (k) begin
          // This sample is the first stable one of the press window.
          state_d = DEB_PRESS;
          cnt_d   = CNT_ONE;
        end
      end

      DEB_PRESS: begin
        if (!k) begin
          // Bounce: abandon the window; the next low restarts it from zero.
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_inc == DEB_TERM) begin
          state_d     = HELD;
          cnt_d       = CNT_ZERO;
          pulse_d     = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          repeating_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end

      HELD: begin
        if (!k) begin
          state_d = DEB_REL;
          cnt_d   = CNT_ONE;
        end else begin
`ifdef KEY_AUTOREPEAT_EN
          // Repeat timer measured from HELD entry; reloads on every repeat.
          if (cnt_inc == (repeating ? RATE_TERM : DELAY_TERM)) begin
            pulse_d     = 1'b1;
            cnt_d       = CNT_ZERO;
            repeating_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
`else
          cnt_d = CNT_ZERO;
`endif
        end
      end

      DEB_REL: begin
        if (k) begin
          // Release bounce: back to HELD without a new pulse. The repeat
          // schedule starts over, first repeat again REPEAT_DELAY away.
          state_d     = HELD;
          cnt_d       = CNT_ZERO;
`ifdef KEY_AUTOREPEAT_EN
          repeating_d = 1'b0;
`endif
        end else if (cnt_inc == DEB_TERM) begin
          state_d    = IDLE;
          cnt_d      = CNT_ZERO;
          released_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Level output follows the next state so it rises with pulse and falls
    // with released on the same edge.
    pressed_d = (state_d == HELD) || (state_d == DEB_REL);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state    <= IDLE;
      cnt      <= CNT_ZERO;
      pulse    <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pulse    <= pulse_d;
      pressed  <= pressed_d;
      released <= released_d;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      repeating <= 1'b0;
    end else begin
      repeating <= repeating_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Output protocol properties.
  // ---------------------------------------------------------------------------
  a_pulse_release_exclusive : assert property (
    @(posedge clk) disable iff (areset) !(pulse && released));

  a_pulse_single_cycle : assert property (
    @(posedge clk) disable iff (areset) pulse |=> !pulse);

  a_released_single_cycle : assert property (
    @(posedge clk) disable iff (areset) released |=> !released);

endmodule

// File: tb/tb_key_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_pulse_conditioner
//
// Directed bench for key_pulse_conditioner with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10, REPEAT_RATE=3. Inputs change 1 ns after a rising edge and
// are captured by the next edge; outputs are sampled 1 ns after each edge.
// In every scenario r is the index of the edge that captures the r-th key_n
// value driven, counting from 0.
// -----------------------------------------------------------------------------
module tb_key_pulse_conditioner;

  localparam int DEB  = 4;
  localparam int RDLY = 10;
  localparam int RRAT = 3;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AUTOREP      = 1'b1;
  localparam int HOLD_PULSES  = 9;   // first + repeats at +10,13,...,31
`else
  localparam bit AUTOREP      = 1'b0;
  localparam int HOLD_PULSES  = 1;
`endif

  logic clk = 1'b0;
  logic areset;
  logic key_n;
  logic pulse;
  logic pressed;
  logic released;

  int checks = 0;
  int passed = 0;

  // Downstream 4-bit counter using pulse as its count enable.
  logic [3:0] hex_count;

  key_pulse_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RDLY),
    .REPEAT_RATE     (RRAT)
  ) dut (
    .clk      (clk),
    .areset   (areset),
    .key_n    (key_n),
    .pulse    (pulse),
    .pressed  (pressed),
    .released (released)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge areset) begin
    if (areset) hex_count <= 4'd0;
    else if (pulse) hex_count <= hex_count + 4'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    key_n = 1'b1;
    repeat (n) tick();
  endtask

  // Expected {pulse, pressed, released} at edge r for a press whose first
  // pulse lands at edge p0, whose HELD state was last (re)entered at edge rs,
  // and whose final release is captured at edge rel.
  // Press accepted: pulse/pressed at p0. Release: k stays 1 through rel+1,
  // released and pressed drop at rel+1+DEB. Repeats (build option) at
  // rs+RDLY, then every RRAT while HELD (last HELD sample is edge rel+1).
  function automatic logic [2:0] expect_out(input int r, input int p0,
                                             input int rs, input int rel);
    logic p;
    logic pr;
    logic rl;
    pr = (r >= p0) && (r < rel + 1 + DEB);
    rl = (r == rel + 1 + DEB);
    p  = (r == p0);
    if (AUTOREP && (r >= rs + RDLY) && (r <= rel + 1) &&
        (((r - rs - RDLY) % RRAT) == 0))
      p = 1'b1;
    return {p, pr, rl};
  endfunction

  // Reset values, then a key held through reset: debounced as a new press.
  task automatic test_reset();
    logic [2:0] got;
    logic [2:0] exp;
    areset = 1'b0;
    key_n  = 1'b0;
    #2 areset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {pulse, pressed, released};
      checks++;
      if (got !== 3'b000)
        $display("FAIL reset_values cycle %0d: got %b expected 000", i, got);
      else passed++;
    end
    areset = 1'b0;                       // deasserted after edge 0
    for (int r = 1; r < 20; r++) begin
      key_n = (r >= 10);
      tick();
      got = {pulse, pressed, released};
      exp = expect_out(r, 6, 6, 10);
      checks++;
      if (got !== exp)
        $display("FAIL powerup_press edge %0d: got %b expected %b", r, got, exp);
      else passed++;
    end
  endtask

  // Press captured at edge 0, release captured at edge 20.
  task automatic test_clean_press();
    logic [2:0] got;
    logic [2:0] exp;
    for (int r = 0; r < 30; r++) begin
      key_n = (r >= 20);
      tick();
      got = {pulse, pressed, released};
      exp = expect_out(r, 5, 5, 20);
      checks++;
      if (got !== exp)
        $display("FAIL clean_press edge %0d: got %b expected %b", r, got, exp);
      else passed++;
    end
  endtask

  // Low 3, high 1, low 2, high 2: all shorter than the window, so nothing.
  // Steady low from edge 8 -> pulse at 13; release captured at 17.
  task automatic test_bounce();
    logic [2:0] got;
    logic [2:0] exp;
    for (int r = 0; r < 27; r++) begin
      key_n = !((r < 3) || (r >= 4 && r < 6) || (r >= 8 && r < 17));
      tick();
      got = {pulse, pressed, released};
      exp = expect_out(r, 13, 13, 17);
      checks++;
      if (got !== exp)
        $display("FAIL press_bounce edge %0d: got %b expected %b", r, got, exp);
      else passed++;
    end
  endtask

  // HELD from edge 5; key high at edges 8-9 (DEB_REL at 10-11, back to HELD
  // at 12); final release captured at 20.
  task automatic test_release_bounce();
    logic [2:0] got;
    logic [2:0] exp;
    for (int r = 0; r < 30; r++) begin
      key_n = !((r < 8) || (r >= 10 && r < 20));
      tick();
      got = {pulse, pressed, released};
      exp = expect_out(r, 5, 12, 20);
      checks++;
      if (got !== exp)
        $display("FAIL release_bounce edge %0d: got %b expected %b", r, got, exp);
      else passed++;
    end
  endtask

  // Key held from edge 0; areset asserted between edges after edge stop_r
  // and held through edge 6, deasserted after edge 6. Outputs clear without
  // waiting for a clock edge; the still-held key pulses at edge 6+6 = 12.
  task automatic test_reset_mid(input int stop_r, input string name);
    logic [2:0] got;
    logic [2:0] exp;
    for (int r = 0; r <= stop_r; r++) begin
      key_n = 1'b0;
      tick();
      got = {pulse, pressed, released};
      exp = expect_out(r, 5, 5, 99);
      checks++;
      if (got !== exp)
        $display("FAIL %s pre_reset edge %0d: got %b expected %b", name, r, got, exp);
      else passed++;
    end
    #3 areset = 1'b1;
    #1;
    got = {pulse, pressed, released};
    checks++;
    if (got !== 3'b000)
      $display("FAIL %s async_clear: got %b expected 000", name, got);
    else passed++;
    for (int r = stop_r + 1; r <= 6; r++) begin
      tick();
      got = {pulse, pressed, released};
      checks++;
      if (got !== 3'b000)
        $display("FAIL %s in_reset edge %0d: got %b expected 000", name, r, got);
      else passed++;
    end
    areset = 1'b0;
    for (int r = 7; r < 25; r++) begin
      key_n = (r >= 16);
      tick();
      got = {pulse, pressed, released};
      exp = expect_out(r, 12, 12, 16);
      checks++;
      if (got !== exp)
        $display("FAIL %s after_reset edge %0d: got %b expected %b", name, r, got, exp);
      else passed++;
    end
  endtask

  // Long hold: first pulse at 5, release captured at 35 (31 HELD samples
  // after the first pulse).
  task automatic test_autorepeat();
    logic [2:0] got;
    logic [2:0] exp;
    int n_pulses;
    n_pulses = 0;
    for (int r = 0; r < 46; r++) begin
      key_n = (r >= 35);
      tick();
      got = {pulse, pressed, released};
      if (pulse === 1'b1) n_pulses++;
      exp = expect_out(r, 5, 5, 35);
      checks++;
      if (got !== exp)
        $display("FAIL autorepeat edge %0d: got %b expected %b", r, got, exp);
      else passed++;
    end
    checks++;
    if (n_pulses !== HOLD_PULSES)
      $display("FAIL autorepeat_count: got %0d pulses expected %0d", n_pulses, HOLD_PULSES);
    else passed++;
  endtask

  // 17 clean presses into the 4-bit counter: 1..F, 0, 1.
  task automatic test_counter_integration();
    logic [3:0] exp_cnt;
    #2 areset = 1'b1;
    tick();
    areset = 1'b0;
    checks++;
    if (hex_count !== 4'd0)
      $display("FAIL counter_reset: got %h expected 0", hex_count);
    else passed++;
    for (int i = 0; i < 17; i++) begin
      for (int r = 0; r < 15; r++) begin
        key_n = (r >= 7);
        tick();
      end
      exp_cnt = 4'((i + 1) % 16);
      checks++;
      if (hex_count !== exp_cnt || pressed !== 1'b0)
        $display("FAIL counter press %0d: got count %h pressed %b expected count %h pressed 0",
                 i + 1, hex_count, pressed, exp_cnt);
      else passed++;
    end
  endtask

  initial begin
    key_n  = 1'b1;
    areset = 1'b0;
    test_reset();
    idle(6);
    test_clean_press();
    idle(6);
    test_bounce();
    idle(6);
    test_release_bounce();
    idle(6);
    test_reset_mid(4, "reset_in_deb_press");
    idle(6);
    test_reset_mid(5, "reset_in_held");
    idle(6);
    test_autorepeat();
    idle(6);
    test_counter_integration();
    idle(4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
